// File: rtl/lock_input_conditioner_if.sv
// lock_input_conditioner_if: raw lock inputs and conditioned command outputs
interface lock_input_conditioner_if #(parameter int CODE_W = 7);
  logic              check_btn_in;
  logic              set_btn_in;
  logic [CODE_W-1:0] code_in;
  logic              check_pulse;
  logic              set_pulse;
  logic [CODE_W-1:0] code_out;
  logic              check_held;
  logic              set_held;
  modport master (
    output check_btn_in, set_btn_in, code_in,
    input  check_pulse, set_pulse, code_out, check_held, set_held
  );
  modport slave (
    input  check_btn_in, set_btn_in, code_in,
    output check_pulse, set_pulse, code_out, check_held, set_held
  );
endinterface

// File: rtl/lock_input_conditioner.sv
// lock_input_conditioner: synchronizes, debounces and pulses the lock buttons and captures the code
module lock_input_conditioner #(
  parameter int DB_COUNT = 16,
  parameter int CODE_W   = 7
) (
  input logic                   clk,
  input logic                   rst,
  lock_input_conditioner_if.slave bus
);
  localparam int CW = $clog2(DB_COUNT);
  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  logic [CODE_W+1:0] sync1, sync2;
  logic [CODE_W-1:0] code_s, code_q;
  logic [1:0]        btn_s;
  logic              check_q, set_q;
  assign code_s = sync2[CODE_W-1:0];
  assign btn_s  = sync2[CODE_W+1:CODE_W];
  // two-flop synchronizer for both buttons and every code bit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {bus.set_btn_in, bus.check_btn_in, bus.code_in};
      sync2 <= sync1;
    end
  // index 0 is the check button, index 1 the set button
  for (genvar b = 0; b < 2; b++) begin : g_btn
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          s, done, acc, held;
    assign s    = btn_s[b];
    assign done = cnt == CW'(DB_COUNT - 1);
    assign held = state == PRESSED || state == RELEASE_WAIT;
    // debounce state and stability counter
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        state <= RELEASED;
        cnt   <= '0;
      end else begin
        state <= state_n;
        cnt   <= cnt_n;
      end
    // next state; acc flags the edge on which a press is accepted
    always_comb begin
      state_n = state;
      cnt_n   = cnt;
      acc     = 1'b0;
      case (state)
        RELEASED:
          if (s) begin
            state_n = PRESS_WAIT;
            cnt_n   = '0;
          end
        PRESS_WAIT:
          if (!s) begin
            state_n = RELEASED;
            cnt_n   = '0;
          end else if (done) begin
            state_n = PRESSED;
            cnt_n   = '0;
            acc     = 1'b1;
          end else cnt_n = cnt + CW'(1);
        PRESSED:
          if (!s) begin
            state_n = RELEASE_WAIT;
            cnt_n   = '0;
          end
        default:
          if (s) begin
            state_n = PRESSED;
            cnt_n   = '0;
          end else if (done) begin
            state_n = RELEASED;
            cnt_n   = '0;
          end else cnt_n = cnt + CW'(1);
      endcase
    end
  end
  // registered pulses with set taking priority; code latched alongside any pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      check_q <= 1'b0;
      set_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      set_q   <= g_btn[1].acc;
      check_q <= g_btn[0].acc & ~g_btn[1].acc;
      if (g_btn[0].acc | g_btn[1].acc) code_q <= code_s;
    end
  assign bus.check_pulse = check_q;
  assign bus.set_pulse   = set_q;
  assign bus.code_out    = code_q;
  assign bus.check_held  = g_btn[0].held;
  assign bus.set_held    = g_btn[1].held;
endmodule

// File: tb/tb_lock_input_conditioner.sv
// tb_lock_input_conditioner: directed checks of debounce, pulse timing, priority and code capture
module tb_lock_input_conditioner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0, n_err = 0;
  int   chk_cnt = 0, set_cnt = 0, both_hi = 0;
  lock_input_conditioner_if #(.CODE_W(7)) bus();
  lock_input_conditioner #(.DB_COUNT(4), .CODE_W(7)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.check_pulse) chk_cnt++;
    if (bus.set_pulse) set_cnt++;
    if (bus.check_pulse && bus.set_pulse) both_hi++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    bus.check_btn_in = 1'b0;
    bus.set_btn_in   = 1'b0;
    bus.code_in      = 7'h00;
    wait_n(2);
    chk("rst_check_pulse", 32'(bus.check_pulse), 0);
    chk("rst_set_pulse", 32'(bus.set_pulse), 0);
    chk("rst_code_out", 32'(bus.code_out), 0);
    chk("rst_check_held", 32'(bus.check_held), 0);
    chk("rst_set_held", 32'(bus.set_held), 0);
    rst = 1'b0;
    wait_n(3);
    bus.code_in = 7'h2A;
    bus.check_btn_in = 1'b1;
    wait_n(6);
    chk("clean_pre", 32'(bus.check_pulse), 0);
    wait_n(1);
    chk("clean_pulse", 32'(bus.check_pulse), 1);
    chk("clean_code", 32'(bus.code_out), 32'h2A);
    chk("clean_set", 32'(bus.set_pulse), 0);
    chk("clean_held", 32'(bus.check_held), 1);
    wait_n(1);
    chk("clean_post", 32'(bus.check_pulse), 0);
    wait_n(12);
    bus.check_btn_in = 1'b0;
    wait_n(15);
    chk("clean_released", 32'(bus.check_held), 0);
    chk("clean_count", 32'(chk_cnt), 1);
    bus.check_btn_in = 1'b1;
    wait_n(3);
    bus.check_btn_in = 1'b0;
    wait_n(10);
    chk("bounce_count", 32'(chk_cnt), 1);
    chk("bounce_held", 32'(bus.check_held), 0);
    bus.check_btn_in = 1'b1;
    wait_n(7);
    chk("rehold_pulse", 32'(bus.check_pulse), 1);
    wait_n(3);
    chk("rehold_held", 32'(bus.check_held), 1);
    bus.check_btn_in = 1'b0;
    wait_n(2);
    bus.check_btn_in = 1'b1;
    wait_n(1);
    bus.check_btn_in = 1'b0;
    wait_n(6);
    chk("relbounce_still_held", 32'(bus.check_held), 1);
    wait_n(1);
    chk("relbounce_fall", 32'(bus.check_held), 0);
    wait_n(5);
    chk("relbounce_count", 32'(chk_cnt), 2);
    bus.code_in = 7'h11;
    bus.check_btn_in = 1'b1;
    bus.set_btn_in = 1'b1;
    wait_n(7);
    chk("simul_set", 32'(bus.set_pulse), 1);
    chk("simul_check", 32'(bus.check_pulse), 0);
    chk("simul_code", 32'(bus.code_out), 32'h11);
    wait_n(3);
    chk("simul_held", 32'({bus.set_held, bus.check_held}), 32'h3);
    chk("simul_check_count", 32'(chk_cnt), 2);
    chk("simul_set_count", 32'(set_cnt), 1);
    bus.check_btn_in = 1'b0;
    bus.set_btn_in = 1'b0;
    wait_n(15);
    bus.code_in = 7'h05;
    bus.check_btn_in = 1'b1;
    wait_n(5);
    rst = 1'b1;
    #1;
    chk("midrst_code", 32'(bus.code_out), 0);
    chk("midrst_pulses", 32'({bus.set_pulse, bus.check_pulse}), 0);
    chk("midrst_held", 32'({bus.set_held, bus.check_held}), 0);
    wait_n(2);
    rst = 1'b0;
    wait_n(6);
    chk("postrst_pre", 32'(bus.check_pulse), 0);
    wait_n(1);
    chk("postrst_pulse", 32'(bus.check_pulse), 1);
    chk("postrst_code", 32'(bus.code_out), 32'h05);
    bus.code_in = 7'h7F;
    wait_n(10);
    chk("stable_code", 32'(bus.code_out), 32'h05);
    chk("stable_count", 32'(chk_cnt), 3);
    bus.check_btn_in = 1'b0;
    wait_n(15);
    bus.code_in = 7'h33;
    bus.set_btn_in = 1'b1;
    wait_n(7);
    chk("set_pulse", 32'(bus.set_pulse), 1);
    chk("set_code", 32'(bus.code_out), 32'h33);
    bus.set_btn_in = 1'b0;
    wait_n(15);
    chk("final_check_count", 32'(chk_cnt), 3);
    chk("final_set_count", 32'(set_cnt), 2);
    chk("never_both", 32'(both_hi), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
